reg2tl_host: RTL and testbench
==============================

REG2TL_HOST -- requirements
Module: reg2tl_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles from A-beat offer to D-beat acceptance before error completion; legal range 1..65535.
REQ-002 Parameter SOURCE_ID, default 0: value driven on a_source and required on d_source.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 host_i_req_valid  in  1  register-style request present.
REQ-006 host_o_req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-007 host_i_address  in  32  byte address; bits [1:0] ignored.
REQ-008 host_i_w_en  in  1  1=write, 0=read.
REQ-009 host_i_wmask  in  4  byte enables for writes.
REQ-010 host_i_wdata  in  32  write data.
REQ-011 host_o_resp_valid  out  1  one-cycle completion pulse.
REQ-012 host_o_rdata  out  32  read data; valid with resp_valid.
REQ-013 host_o_err  out  1  completion error flag; valid with resp_valid.
REQ-014 host_o_tl_a_{opcode,param,size,source,address,mask,data,corrupt,valid}  out  TL_A widths  TileLink-UL A channel; host_i_tl_a_ready in 1.
REQ-015 host_i_tl_d_{opcode,param,size,source,sink,denied,data,corrupt,valid}  in  TL_D widths  TileLink-UL D channel; host_o_tl_d_ready out 1.

Function
REQ-016 The block SHALL implement FSM states IDLE, A_SEND, D_WAIT, RESP; one outstanding transaction max.
REQ-017 IDLE: req_ready=1; req_valid&&req_ready SHALL latch address, w_en, wmask, wdata and go to A_SEND next cycle.
REQ-018 A_SEND: a_valid=1; all A fields SHALL come from latched registers and stay stable until a_valid&&a_ready.
REQ-019 A opcode SHALL be Get(4) for reads, PutFullData(0) for writes with wmask=4'hF, PutPartialData(1) otherwise.
REQ-020 A fields: param=0, size=2, source=SOURCE_ID, address={addr[31:2],2'b00}, mask=4'hF for reads else wmask, data=wdata for writes else 0, corrupt=0.
REQ-021 A-beat handshake SHALL move FSM to D_WAIT next cycle.
REQ-022 D_WAIT: d_ready=1; on d_valid the block SHALL latch d_data (reads) and go to RESP.
REQ-023 err SHALL be set if d_denied=1, d_corrupt=1, d_source!=SOURCE_ID, or d_opcode mismatches (read expects AccessAckData(1), write expects AccessAck(0)).
REQ-024 rdata SHALL be 0 for writes and for any errored completion.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in RESP.
REQ-026 Timeout counter (16 bit) SHALL clear on request accept, increment each cycle in A_SEND/D_WAIT, and on reaching TIMEOUT_CYCLES force RESP with err=1, rdata=0.
REQ-027 Timeout in A_SEND SHALL drop a_valid in the same cycle FSM leaves A_SEND; a simultaneous a_ready is not a handshake.
REQ-028 Simultaneous d_valid and timeout in D_WAIT: D beat wins, err per REQ-023.
REQ-029 d_ready SHALL be 1 in IDLE; D beats arriving in IDLE are silently discarded (stale post-timeout responses); d_ready=0 in A_SEND and RESP.
REQ-030 Minimum latency: req accept cycle N, A beat N+1, D beat N+2, resp_valid N+3.
REQ-031 req_valid/inputs in states other than IDLE SHALL be ignored.

Reset
REQ-032 rst low SHALL asynchronously force IDLE, counter=0, all latched registers=0.
REQ-033 Reset values: req_ready=1, resp_valid=0, rdata=0, err=0, a_valid=0, all A fields=0, d_ready=1.
REQ-034 Reset mid-transaction SHALL abandon it with no resp_valid; later D beat discarded per REQ-029.

Verification
REQ-035 Read 0x0000_0004, a_ready=1, D AccessAckData data=0x0000_00A5 next cycle -> a_opcode=4, mask=F, resp_valid at N+3, rdata=0x0000_00A5, err=0.
REQ-036 Write addr 0x0000_0007 wmask=0x3 wdata=0x1234_5678, a_ready delayed 3 cycles -> a_opcode=1, address=0x0000_0004, fields stable while stalled, AccessAck -> err=0, rdata=0.
REQ-037 Read answered with d_denied=1 -> resp_valid, err=1, rdata=0; second, d_source=1 with SOURCE_ID=0 -> err=1.
REQ-038 TIMEOUT_CYCLES=4, D never returned -> resp_valid 4 cycles after A offer, err=1; late D beat in IDLE discarded, next read completes normally.
REQ-039 rst low during D_WAIT -> outputs at reset values immediately, no resp_valid; after release new write wmask=F gives a_opcode=0.

Source files
------------

// File: rtl/reg2tl_host.sv
// reg2tl_host: bridges a simple register-style request port onto a
// TileLink-UL host interface, with one transaction outstanding at a time.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   host_i_req_valid / _o_req_ready
//                                request handshake (ready only while idle)
//   host_i_address/_w_en/_wmask/_wdata
//                                request fields, latched on accept
//   host_o_resp_valid/_rdata/_err
//                                one-cycle completion pulse and its result
//   host_o_tl_a_* / host_i_tl_a_ready
//                                TL-UL A channel (Get / PutFull / PutPartial)
//   host_i_tl_d_* / host_o_tl_d_ready
//                                TL-UL D channel (AccessAck / AccessAckData)
//
// A per-transaction timeout counter turns a stalled A beat or a missing
// D beat into an error completion, so the register side never hangs.
module reg2tl_host #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  SOURCE_ID      = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_i_req_valid,
  output logic        host_o_req_ready,
  input  logic [31:0] host_i_address,
  input  logic        host_i_w_en,
  input  logic [3:0]  host_i_wmask,
  input  logic [31:0] host_i_wdata,
  output logic        host_o_resp_valid,
  output logic [31:0] host_o_rdata,
  output logic        host_o_err,
  output logic [2:0]  host_o_tl_a_opcode,
  output logic [2:0]  host_o_tl_a_param,
  output logic [1:0]  host_o_tl_a_size,
  output logic [7:0]  host_o_tl_a_source,
  output logic [31:0] host_o_tl_a_address,
  output logic [3:0]  host_o_tl_a_mask,
  output logic [31:0] host_o_tl_a_data,
  output logic        host_o_tl_a_corrupt,
  output logic        host_o_tl_a_valid,
  input  logic        host_i_tl_a_ready,
  input  logic [2:0]  host_i_tl_d_opcode,
  input  logic [2:0]  host_i_tl_d_param,
  input  logic [1:0]  host_i_tl_d_size,
  input  logic [7:0]  host_i_tl_d_source,
  input  logic        host_i_tl_d_sink,
  input  logic        host_i_tl_d_denied,
  input  logic [31:0] host_i_tl_d_data,
  input  logic        host_i_tl_d_corrupt,
  input  logic        host_i_tl_d_valid,
  output logic        host_o_tl_d_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] A_SEND = 2'd1;
  localparam logic [1:0] D_WAIT = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  // Last counter value still inside the window; the cycle holding it is
  // the final one in which the beat may complete.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic in_a, timeout, d_err;

  // Sideband D fields and the ignored byte offset carry no information here.
  logic unused_in;
  assign unused_in = ^{host_i_tl_d_param, host_i_tl_d_size, host_i_tl_d_sink,
                       host_i_address[1:0]};

  assign in_a    = (state_q == A_SEND);
  assign timeout = (state_q == A_SEND || state_q == D_WAIT) && (cnt_q == TO_LAST);
  assign d_err   = host_i_tl_d_denied | host_i_tl_d_corrupt |
                   (host_i_tl_d_source != SOURCE_ID) |
                   (host_i_tl_d_opcode != (we_q ? OP_ACK : OP_ACK_DATA));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (host_i_req_valid) begin
          addr_d  = host_i_address[31:2];
          we_d    = host_i_w_en;
          wmask_d = host_i_wmask;
          wdata_d = host_i_wdata;
          cnt_d   = '0;
          state_d = A_SEND;
        end
      end
      A_SEND: begin
        cnt_d = cnt_q + 16'd1;
        // a_valid is already low on a timeout cycle, so a_ready is ignored.
        if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (host_i_tl_a_ready) begin
          state_d = D_WAIT;
        end
      end
      D_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // An arriving D beat takes priority over an expiring timeout.
        if (host_i_tl_d_valid) begin
          err_d   = d_err;
          rdata_d = (!we_q && !d_err) ? host_i_tl_d_data : '0;
          state_d = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign host_o_req_ready  = (state_q == IDLE);
  assign host_o_resp_valid = (state_q == RESP);
  assign host_o_rdata      = rdata_q;
  assign host_o_err        = err_q;
  // D beats seen while idle are stale post-timeout responses and are dropped.
  assign host_o_tl_d_ready = (state_q == IDLE) || (state_q == D_WAIT);

  // A fields read as zero outside A_SEND so the idle bus is quiet.
  assign host_o_tl_a_valid   = in_a && !timeout;
  assign host_o_tl_a_opcode  = !in_a ? 3'd0 :
                               !we_q ? OP_GET :
                               (wmask_q == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
  assign host_o_tl_a_param   = '0;
  assign host_o_tl_a_size    = in_a ? 2'd2 : 2'd0;
  assign host_o_tl_a_source  = in_a ? SOURCE_ID : 8'd0;
  assign host_o_tl_a_address = in_a ? {addr_q, 2'b00} : '0;
  assign host_o_tl_a_mask    = !in_a ? 4'h0 : (we_q ? wmask_q : 4'hF);
  assign host_o_tl_a_data    = (in_a && we_q) ? wdata_q : '0;
  assign host_o_tl_a_corrupt = 1'b0;

endmodule

// File: tb/tb_reg2tl_host.sv
module tb_reg2tl_host;
  localparam logic [7:0] SRC = 8'd0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sel chooses which instance is exercised: 0 = default timeout, 1 = timeout 4
  logic        sel;
  logic        req_valid, w_en, a_ready, d_sink, d_denied, d_corrupt, d_valid;
  logic [31:0] address, wdata, d_data;
  logic [3:0]  wmask;
  logic [2:0]  d_opcode, d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;

  logic        rr[2], rv[2], er[2], av[2], dr[2], acr[2];
  logic [31:0] rd[2], aad[2], adt[2];
  logic [2:0]  aop[2], apr[2];
  logic [1:0]  asz[2];
  logic [7:0]  asr[2];
  logic [3:0]  amk[2];

  int n_chk = 0;
  int n_pass = 0;

  reg2tl_host #(.TIMEOUT_CYCLES(255), .SOURCE_ID(SRC)) dut0 (
    .clk(clk), .rst(rst),
    .host_i_req_valid(req_valid && !sel), .host_o_req_ready(rr[0]),
    .host_i_address(address), .host_i_w_en(w_en), .host_i_wmask(wmask), .host_i_wdata(wdata),
    .host_o_resp_valid(rv[0]), .host_o_rdata(rd[0]), .host_o_err(er[0]),
    .host_o_tl_a_opcode(aop[0]), .host_o_tl_a_param(apr[0]), .host_o_tl_a_size(asz[0]),
    .host_o_tl_a_source(asr[0]), .host_o_tl_a_address(aad[0]), .host_o_tl_a_mask(amk[0]),
    .host_o_tl_a_data(adt[0]), .host_o_tl_a_corrupt(acr[0]), .host_o_tl_a_valid(av[0]),
    .host_i_tl_a_ready(a_ready),
    .host_i_tl_d_opcode(d_opcode), .host_i_tl_d_param(d_param), .host_i_tl_d_size(d_size),
    .host_i_tl_d_source(d_source), .host_i_tl_d_sink(d_sink), .host_i_tl_d_denied(d_denied),
    .host_i_tl_d_data(d_data), .host_i_tl_d_corrupt(d_corrupt), .host_i_tl_d_valid(d_valid),
    .host_o_tl_d_ready(dr[0])
  );

  reg2tl_host #(.TIMEOUT_CYCLES(4), .SOURCE_ID(SRC)) dut1 (
    .clk(clk), .rst(rst),
    .host_i_req_valid(req_valid && sel), .host_o_req_ready(rr[1]),
    .host_i_address(address), .host_i_w_en(w_en), .host_i_wmask(wmask), .host_i_wdata(wdata),
    .host_o_resp_valid(rv[1]), .host_o_rdata(rd[1]), .host_o_err(er[1]),
    .host_o_tl_a_opcode(aop[1]), .host_o_tl_a_param(apr[1]), .host_o_tl_a_size(asz[1]),
    .host_o_tl_a_source(asr[1]), .host_o_tl_a_address(aad[1]), .host_o_tl_a_mask(amk[1]),
    .host_o_tl_a_data(adt[1]), .host_o_tl_a_corrupt(acr[1]), .host_o_tl_a_valid(av[1]),
    .host_i_tl_a_ready(a_ready),
    .host_i_tl_d_opcode(d_opcode), .host_i_tl_d_param(d_param), .host_i_tl_d_size(d_size),
    .host_i_tl_d_source(d_source), .host_i_tl_d_sink(d_sink), .host_i_tl_d_denied(d_denied),
    .host_i_tl_d_data(d_data), .host_i_tl_d_corrupt(d_corrupt), .host_i_tl_d_valid(d_valid),
    .host_o_tl_d_ready(dr[1])
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [84:0] a_beat();
    return {aop[sel], apr[sel], asz[sel], asr[sel], aad[sel], amk[sel], adt[sel], acr[sel]};
  endfunction

  // One complete transaction with a reference model of the expected A beat,
  // completion timing (t counts cycles since the A beat was first offered;
  // the window closes at t = timeout-1) and completion result.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] wm,
                         input logic [31:0] wd, input int a_dly, input int d_dly,
                         input bit d_never, input logic [2:0] dop, input logic dden,
                         input logic dcor, input logic [7:0] dsrc, input logic [31:0] ddata);
    logic [84:0] exp_a;
    logic        e_err;
    logic [31:0] e_rd;
    int          to_cur, t_end, c0;
    bit          tmo, a_done, dacc;
    to_cur = sel ? 4 : 255;
    exp_a  = {(we ? ((wm == 4'hF) ? 3'd0 : 3'd1) : 3'd4), 3'd0, 2'd2, SRC,
              addr[31:2], 2'b00, (we ? wm : 4'hF), (we ? wd : 32'h0), 1'b0};
    tmo = 0; a_done = 0; dacc = 0; t_end = 0;
    @(negedge clk);
    chk("req_ready_idle", rr[sel], 1'b1);
    req_valid = 1'b1; address = addr; w_en = we; wmask = wm; wdata = wd;
    c0 = cyc;
    @(posedge clk);
    for (int k = 0; k < to_cur && !a_done && !tmo; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 1'b0; address = $urandom; w_en = 1'($urandom);
        wmask = 4'($urandom); wdata = $urandom;
      end
      chk("d_ready_asend", dr[sel], 1'b0);
      chk("resp_valid_asend", rv[sel], 1'b0);
      if (k == to_cur - 1) begin
        chk("a_valid_timeout", av[sel], 1'b0);
        tmo = 1;
      end else begin
        chk("a_valid", av[sel], 1'b1);
        chk("a_beat", a_beat(), exp_a);
      end
      a_ready = (k >= a_dly);
      @(posedge clk);
      t_end = k;
      if (!tmo && a_ready) a_done = 1;
    end
    if (a_done) begin
      for (int k = t_end + 1; k < to_cur && !dacc && !tmo; k++) begin
        @(negedge clk);
        a_ready = 1'b0;
        chk("a_valid_dwait", av[sel], 1'b0);
        chk("d_ready_dwait", dr[sel], 1'b1);
        chk("resp_valid_dwait", rv[sel], 1'b0);
        d_valid = !d_never && (k - t_end - 1 >= d_dly);
        d_opcode = dop; d_denied = dden; d_corrupt = dcor; d_source = dsrc; d_data = ddata;
        d_param = 3'($urandom); d_size = 2'($urandom); d_sink = 1'($urandom);
        @(posedge clk);
        t_end = k;
        if (d_valid) dacc = 1;
        else if (k == to_cur - 1) tmo = 1;
      end
    end
    @(negedge clk);
    a_ready = 1'b0; d_valid = 1'b0;
    e_err = tmo || dden || dcor || (dsrc != SRC) || (dop != (we ? 3'd0 : 3'd1));
    e_rd  = (!we && !e_err) ? ddata : 32'h0;
    chk("resp_valid", rv[sel], 1'b1);
    chk("req_ready_resp", rr[sel], 1'b0);
    chk("err", er[sel], e_err);
    chk("rdata", rd[sel], e_rd);
    chk("latency", 32'(cyc - c0), 32'(t_end + 2));
    @(negedge clk);
    chk("resp_pulse_end", rv[sel], 1'b0);
    chk("req_ready_back", rr[sel], 1'b1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", rr[sel], 1'b1);
    chk("rst_resp_valid", rv[sel], 1'b0);
    chk("rst_rdata", rd[sel], 32'h0);
    chk("rst_err", er[sel], 1'b0);
    chk("rst_a_valid", av[sel], 1'b0);
    chk("rst_a_fields", a_beat(), 85'h0);
    chk("rst_d_ready", dr[sel], 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; req_valid = 0; address = 0; w_en = 0; wmask = 0; wdata = 0; a_ready = 0;
    d_opcode = 0; d_param = 0; d_size = 0; d_source = 0; d_sink = 0; d_denied = 0;
    d_data = 0; d_corrupt = 0; d_valid = 0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1 chk_reset_vals();
    end
    sel = 1'b0;
    @(negedge clk) rst = 1'b1;

    // Minimum-latency read
    run_txn(32'h0000_0004, 1'b0, 4'h0, 32'h0, 0, 0, 0, 3'd1, 0, 0, SRC, 32'h0000_00A5);
    // Partial write with A stalled 3 cycles
    run_txn(32'h0000_0007, 1'b1, 4'h3, 32'h1234_5678, 3, 0, 0, 3'd0, 0, 0, SRC, 32'hDEAD_BEEF);
    // Denied read, then wrong source
    run_txn(32'h0000_0010, 1'b0, 4'h0, 32'h0, 0, 1, 0, 3'd1, 1, 0, SRC, 32'h5555_AAAA);
    run_txn(32'h0000_0014, 1'b0, 4'h0, 32'h0, 0, 0, 0, 3'd1, 0, 0, 8'd1, 32'h1111_2222);

    // Timeout of 4, D never returned; then stale D in idle; then normal read
    sel = 1'b1;
    run_txn(32'h0000_0020, 1'b0, 4'h0, 32'h0, 0, 0, 1, 3'd1, 0, 0, SRC, 32'h0);
    d_valid = 1'b1; d_opcode = 3'd1; d_source = SRC; d_data = 32'hCAFE_F00D;
    chk("d_ready_idle", dr[sel], 1'b1);
    @(negedge clk);
    d_valid = 1'b0;
    chk("stale_d_no_resp", rv[sel], 1'b0);
    chk("stale_d_idle", rr[sel], 1'b1);
    run_txn(32'h0000_0024, 1'b0, 4'h0, 32'h0, 0, 0, 0, 3'd1, 0, 0, SRC, 32'h0BAD_C0DE);

    // Reset while waiting for D
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; address = 32'h40; w_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; a_ready = 1'b1;
    chk("pre_rst_a_valid", av[sel], 1'b1);
    @(negedge clk);
    a_ready = 1'b0;
    chk("pre_rst_dwait", dr[sel], 1'b1);
    #2 rst = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk) rst = 1'b1;
    d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_valid = 1'b0;
      chk("post_rst_no_resp", rv[sel], 1'b0);
    end
    run_txn(32'h0000_0100, 1'b1, 4'hF, 32'hA5A5_5A5A, 0, 0, 0, 3'd0, 0, 0, SRC, 32'h0);

    // Randomized transactions on both instances
    for (int i = 0; i < 48; i++) begin
      logic we;
      logic [3:0] wm;
      logic [2:0] dop;
      sel = (i % 3 != 0);
      we  = 1'($urandom);
      wm  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      dop = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (we ? 3'd0 : 3'd1);
      run_txn($urandom, we, wm, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
              ($urandom_range(0, 7) == 0), dop, ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : SRC, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
